ps2_scancode_rx: RTL and testbench

PS/2 keyboard receive front-end that sits directly upstream of the Keyboard matrix block. It deserialises PS/2 device-to-host frames from the raw PS2_CLK/PS2_DATA pins and checks framing and parity. It resolves E0/F0/E1 prefixes and delivers one registered key event per make or break code, so the matrix block only ever sees clean scancode events.

---
 rtl/ps2_scancode_rx.sv | 171 +++++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: pin conditioning, frame FSM with timeout,
// and E0/F0/E1 prefix decoding into one registered key event per code.
//
// state  | meaning
// IDLE   | waiting for start bit (data 0 on falling edge)
// DATA   | shifting 8 data bits, LSB first
// PARITY | latching odd-parity bit
// STOP   | checking stop bit and parity, accepting byte
`timescale 1ns/1ps
module ps2_scancode_rx #(
   parameter int FILTER  = 4,
   parameter int TIMEOUT = 2000
) (
   input  logic       clk,
   input  logic       RESET,
   input  logic       clk_en,
   input  logic       PS2_CLK,
   input  logic       PS2_DATA,
   output logic [7:0] SCANCODE,
   output logic       EXTENDED,
   output logic       RELEASED,
   output logic       VALID,
   output logic       ERROR
);
   localparam int FW = $clog2(FILTER + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   state_t          state, state_nx;
   logic [1:0]      clk_sync, dat_sync;
   logic            clk_f, dat_f, clk_flip, dat_flip, fall;
   logic [FW-1:0]   clk_fcnt, dat_fcnt;
   logic [TW-1:0]   tmo_cnt;
   logic [2:0]      bit_cnt;
   logic [7:0]      shreg;
   logic            par_bit;
   logic            byte_ok, frm_err, tmo_hit, resp;
   logic            ext_flag, brk_flag;
   logic [2:0]      swallow;

   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
      end else begin
         clk_sync <= {clk_sync[0], PS2_CLK};
         dat_sync <= {dat_sync[0], PS2_DATA};
      end
   end

   // A level flips once the synchronised pin has disagreed for FILTER enabled samples.
   always_comb begin
      clk_flip = clk_en && (clk_sync[1] != clk_f) && (clk_fcnt == FW'(FILTER - 1));
      dat_flip = clk_en && (dat_sync[1] != dat_f) && (dat_fcnt == FW'(FILTER - 1));
      fall     = clk_flip && clk_f;
   end

   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         clk_f    <= 1'b1;
         dat_f    <= 1'b1;
         clk_fcnt <= '0;
         dat_fcnt <= '0;
      end else if (clk_en) begin
         if (clk_sync[1] == clk_f) clk_fcnt <= '0;
         else if (clk_flip) begin
            clk_f    <= ~clk_f;
            clk_fcnt <= '0;
         end else clk_fcnt <= clk_fcnt + 1'b1;
         if (dat_sync[1] == dat_f) dat_fcnt <= '0;
         else if (dat_flip) begin
            dat_f    <= ~dat_f;
            dat_fcnt <= '0;
         end else dat_fcnt <= dat_fcnt + 1'b1;
      end
   end

   always_comb begin
      state_nx = state;
      byte_ok  = 1'b0;
      frm_err  = 1'b0;
      tmo_hit  = clk_en && !fall && (state != S_IDLE) && (tmo_cnt == '0);
      if (fall) begin
         case (state)
            S_IDLE:   if (!dat_f) state_nx = S_DATA;
                      else frm_err = 1'b1;
            S_DATA:   if (bit_cnt == 3'd7) state_nx = S_PARITY;
            S_PARITY: state_nx = S_STOP;
            S_STOP: begin
               if (dat_f && (^{shreg, par_bit})) byte_ok = 1'b1;
               else frm_err = 1'b1;
               state_nx = S_IDLE;
            end
            default:  state_nx = S_IDLE;
         endcase
      end else if (tmo_hit) begin
         frm_err  = 1'b1;
         state_nx = S_IDLE;
      end
   end

   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         state   <= S_IDLE;
         tmo_cnt <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
      end else begin
         state <= state_nx;
         if (fall) tmo_cnt <= TW'(TIMEOUT - 1);
         else if (clk_en && (state != S_IDLE) && (tmo_cnt != '0)) tmo_cnt <= tmo_cnt - 1'b1;
         if (fall) begin
            case (state)
               S_IDLE:   bit_cnt <= '0;
               S_DATA: begin
                  shreg   <= {dat_f, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
               end
               S_PARITY: par_bit <= dat_f;
               default:  ;
            endcase
         end
      end
   end

   always_comb begin
      resp = 1'b0;
      case (shreg)
         8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: resp = 1'b1;
         default: resp = 1'b0;
      endcase
   end

   // The E1 pause sequence is swallowed whole, even bytes that look like prefixes.
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         SCANCODE <= 8'h00;
         EXTENDED <= 1'b0;
         RELEASED <= 1'b0;
         VALID    <= 1'b0;
         ERROR    <= 1'b0;
         ext_flag <= 1'b0;
         brk_flag <= 1'b0;
         swallow  <= '0;
      end else begin
         VALID <= 1'b0;
         ERROR <= 1'b0;
         if (frm_err) begin
            ERROR    <= 1'b1;
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
            swallow  <= '0;
         end else if (byte_ok) begin
            if (swallow != '0) swallow <= swallow - 3'd1;
            else if (shreg == 8'hE1) swallow <= 3'd7;
            else if (shreg == 8'hE0) ext_flag <= 1'b1;
            else if (shreg == 8'hF0) brk_flag <= 1'b1;
            else if (!(resp && !ext_flag && !brk_flag)) begin
               SCANCODE <= shreg;
               EXTENDED <= ext_flag;
               RELEASED <= brk_flag;
               VALID    <= 1'b1;
               ext_flag <= 1'b0;
               brk_flag <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx; expected events are queued as frames
// are sent and checked whenever VALID or ERROR pulses.
`timescale 1ns/1ps
module tb_ps2_scancode_rx;
   localparam int FILTER  = 4;
   localparam int TIMEOUT = 2000;
   localparam int H       = 20;

   logic       clk = 1'b0;
   logic       RESET, clk_en, PS2_CLK, PS2_DATA;
   logic [7:0] SCANCODE;
   logic       EXTENDED, RELEASED, VALID, ERROR;

   typedef struct packed {
      logic       valid;
      logic       err;
      logic [7:0] code;
      logic       ext;
      logic       rel;
   } ev_t;

   ev_t exp_q[$];
   ev_t got, want;
   int  vectors = 0;
   int  miscompares = 0;
   bit  en_toggle = 1'b0;
   bit  en_hold = 1'b0;

   ps2_scancode_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .RESET(RESET), .clk_en(clk_en), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
      .SCANCODE(SCANCODE), .EXTENDED(EXTENDED), .RELEASED(RELEASED),
      .VALID(VALID), .ERROR(ERROR)
   );

   always #5 clk = ~clk;

   initial begin
      clk_en = 1'b1;
      forever begin
         @(negedge clk);
         if (en_hold) clk_en = 1'b0;
         else if (en_toggle) clk_en = ~clk_en;
         else clk_en = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (VALID || ERROR) begin
         got = {VALID, ERROR, ERROR ? 8'h00 : SCANCODE, ERROR ? 1'b0 : EXTENDED, ERROR ? 1'b0 : RELEASED};
         if (exp_q.size() == 0) want = '0;
         else want = exp_q.pop_front();
         vectors++;
         assert (got === want) else begin
            miscompares++;
            $error("FAIL event: observed %h expected %h", got, want);
         end
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, observed running expected done");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [10:0] frame(input logic [7:0] b, input bit badpar);
      return {1'b1, (~^b) ^ badpar, b, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] f, input int n, input int stall_after);
      for (int i = 0; i < n; i++) begin
         PS2_DATA = f[i];
         tick(H);
         PS2_CLK = 1'b0;
         tick(H);
         PS2_CLK = 1'b1;
         if (i == stall_after) begin
            en_hold = 1'b1;
            tick(3 * TIMEOUT);
            en_hold = 1'b0;
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit badpar);
      send_bits(frame(b, badpar), 11, -1);
      PS2_DATA = 1'b1;
      tick(4 * H);
   endtask

   task automatic exp_ev(input logic [7:0] code, input logic ext, input logic rel);
      exp_q.push_back({1'b1, 1'b0, code, ext, rel});
   endtask

   task automatic exp_err();
      exp_q.push_back({1'b0, 1'b1, 8'h00, 1'b0, 1'b0});
   endtask

   task automatic check_drained(input string tag);
      vectors++;
      assert (exp_q.size() == 0) else begin
         miscompares++;
         $error("FAIL %s: observed %0d pending events expected 0", tag, exp_q.size());
      end
   endtask

   task automatic check_reset(input string tag);
      vectors++;
      assert ({SCANCODE, EXTENDED, RELEASED, VALID, ERROR} === 12'h000) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected 000", tag, {SCANCODE, EXTENDED, RELEASED, VALID, ERROR});
      end
   endtask

   initial begin
      RESET = 1'b1;
      PS2_CLK = 1'b1;
      PS2_DATA = 1'b1;
      tick(5);
      check_reset("reset_state");
      RESET = 1'b0;
      tick(20);

      exp_ev(8'h1C, 1'b0, 1'b0);
      send_byte(8'h1C, 1'b0);
      check_drained("make_1c");

      exp_ev(8'h1C, 1'b0, 1'b1);
      send_byte(8'hF0, 1'b0);
      send_byte(8'h1C, 1'b0);
      exp_ev(8'h1C, 1'b0, 1'b0);
      send_byte(8'h1C, 1'b0);
      check_drained("break_1c");

      exp_ev(8'h75, 1'b1, 1'b1);
      send_byte(8'hE0, 1'b0);
      send_byte(8'hF0, 1'b0);
      send_byte(8'h75, 1'b0);
      check_drained("ext_break_75");

      send_byte(8'hE1, 1'b0);
      send_byte(8'h14, 1'b0);
      send_byte(8'h77, 1'b0);
      send_byte(8'hE1, 1'b0);
      send_byte(8'hF0, 1'b0);
      send_byte(8'h14, 1'b0);
      send_byte(8'hF0, 1'b0);
      send_byte(8'h77, 1'b0);
      check_drained("pause_silent");
      exp_ev(8'h1C, 1'b0, 1'b0);
      send_byte(8'h1C, 1'b0);

      send_byte(8'hF0, 1'b0);
      exp_err();
      send_byte(8'h1C, 1'b1);
      exp_ev(8'h1C, 1'b0, 1'b0);
      send_byte(8'h1C, 1'b0);
      check_drained("parity_err");

      send_byte(8'hAA, 1'b0);
      send_byte(8'hFA, 1'b0);
      check_drained("responses_dropped");

      exp_err();
      send_bits(frame(8'h1C, 1'b0), 5, -1);
      PS2_DATA = 1'b1;
      tick(TIMEOUT + 10);
      check_drained("timeout");
      exp_ev(8'h1C, 1'b0, 1'b0);
      send_byte(8'h1C, 1'b0);
      check_drained("after_timeout");

      exp_ev(8'h2D, 1'b0, 1'b0);
      send_bits(frame(8'h2D, 1'b0), 11, 4);
      PS2_DATA = 1'b1;
      tick(4 * H);
      check_drained("clk_en_stall");

      en_toggle = 1'b1;
      exp_ev(8'h1C, 1'b0, 1'b1);
      send_byte(8'hF0, 1'b0);
      send_byte(8'h1C, 1'b0);
      en_toggle = 1'b0;
      tick(4);
      check_drained("clk_en_toggle");

      send_byte(8'hF0, 1'b0);
      send_bits(frame(8'h3A, 1'b0), 6, -1);
      tick(3);
      RESET = 1'b1;
      tick(2);
      check_reset("reset_mid_frame");
      RESET = 1'b0;
      tick(1);
      check_reset("after_reset_release");
      PS2_DATA = 1'b1;
      tick(4 * H);
      exp_ev(8'h2D, 1'b0, 1'b0);
      send_byte(8'h2D, 1'b0);

      tick(100);
      check_drained("final");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
